// File: rtl/chip8_scanout_if.sv
// chip8_scanout_if: VRAM read channel between the scanout block and the
// shared memory arbiter.
//
// Handshake: the requester raises mem_valid_out for one cycle, and only in a
// cycle where mem_ready_in is high. mem_addr_out is valid during that cycle.
// At most one request is outstanding. The arbiter answers later with a
// one-cycle mem_valid_in pulse carrying mem_data_in. mem_type_out selects
// VRAM (1).
interface chip8_scanout_if;
    logic [15:0] mem_addr_out;
    logic        mem_valid_out;
    logic        mem_type_out;
    logic        mem_ready_in;
    logic        mem_valid_in;
    logic [7:0]  mem_data_in;

    modport master (
        output mem_addr_out, mem_valid_out, mem_type_out,
        input  mem_ready_in, mem_valid_in, mem_data_in
    );

    modport slave (
        input  mem_addr_out, mem_valid_out, mem_type_out,
        output mem_ready_in, mem_valid_in, mem_data_in
    );
endinterface

// File: rtl/chip8_scanout.sv
// chip8_scanout: fetches one 64-pixel chip-8 row from VRAM per scaled source
// row into a back line buffer, swaps it into the front buffer at the start of
// the first screen line of that row, and emits a scaled, offset RGB stream.
// Optional macro CHIP8_SCANOUT_BORDER_EN draws a grey 1-pixel frame around
// the window.
module chip8_scanout #(
    parameter int          SCALE_LOG2 = 4,
    parameter int          X_OFFSET   = 128,
    parameter int          Y_OFFSET   = 104,
    parameter int          H_ACTIVE   = 1280,
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic                  new_frame_in,
    input  logic                  ad_in,
    chip8_scanout_if.master       mem,
    output logic [23:0]           pixel_out,
    output logic                  in_window_out,
    output logic                  underrun_out,
    output logic [1:0]            state_dbg_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    localparam int          WIN_W      = 64 << SCALE_LOG2;
    localparam int          WIN_H      = 32 << SCALE_LOG2;
    localparam logic [10:0] X_LO       = 11'(X_OFFSET);
    localparam logic [10:0] X_HI       = 11'(X_OFFSET + WIN_W);
    localparam logic [10:0] Y_LO       = 11'(Y_OFFSET);
    localparam logic [10:0] Y_HI       = 11'(Y_OFFSET + WIN_H);
    localparam logic [10:0] PHASE_MASK = 11'((1 << SCALE_LOG2) - 1);
    localparam logic [10:0] H_END      = 11'(H_ACTIVE);

    state_t      state_q, state_d;
    logic [2:0]  byte_q, byte_d;
    logic [4:0]  row_q, row_d;
    logic [63:0] back_q, back_d;
    logic [63:0] front_q, front_d;
    logic        disp_q, disp_d;
    logic        underrun_q, underrun_d;
    logic [23:0] pixel_q, pixel_d;
    logic        in_window_q, in_window_d;
    logic        req;

    // Position decode shared by the fetch FSM and the pixel path; all
    // subtractions are 11 bits and only used after the bounds checks pass.
    logic [10:0] vcount_ext, nv, nv_rel, v_rel, h_rel;
    logic        nv_in_win, v_in_win, h_in_win, trigger, swap_pt;
    logic [4:0]  row_next;
    logic [5:0]  col;

    assign vcount_ext = {1'b0, vcount_in};
    assign nv         = vcount_ext + 11'd1;
    assign nv_rel     = nv - Y_LO;
    assign v_rel      = vcount_ext - Y_LO;
    assign h_rel      = hcount_in - X_LO;
    assign nv_in_win  = (nv >= Y_LO) && (nv < Y_HI);
    assign v_in_win   = (vcount_ext >= Y_LO) && (vcount_ext < Y_HI);
    assign h_in_win   = (hcount_in >= X_LO) && (hcount_in < X_HI);
    assign trigger    = (hcount_in == H_END) && nv_in_win && ((nv_rel & PHASE_MASK) == 11'd0);
    assign swap_pt    = (hcount_in == 11'd0) && v_in_win && ((v_rel & PHASE_MASK) == 11'd0);
    assign row_next   = 5'(nv_rel >> SCALE_LOG2);
    assign col        = 6'(h_rel >> SCALE_LOG2);

    // Fetch FSM next state, buffer select latch and line-buffer swap/abort.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        row_d      = row_q;
        back_d     = back_q;
        front_d    = front_q;
        disp_d     = disp_q;
        underrun_d = 1'b0;
        req        = 1'b0;

        if (new_frame_in) begin
            disp_d = ~ad_in;
        end

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    row_d   = row_next;
                    byte_d  = 3'd0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem.mem_ready_in) begin
                    req     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_valid_in) begin
                    // Byte 0 lands in bits 63:56 so bit 63 is the leftmost pixel.
                    back_d[{~byte_q, 3'b000} +: 8] = mem.mem_data_in;
                    if (byte_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A row that is not complete by its first display line is dropped
        // and shown blank; any response still in flight is ignored in IDLE.
        if (swap_pt) begin
            if (state_q == DONE) begin
                front_d = back_q;
            end else begin
                front_d    = 64'd0;
                underrun_d = 1'b1;
                req        = 1'b0;
            end
            state_d = IDLE;
        end
    end

    // Pixel colour and window flag for the current position.
    always_comb begin
        in_window_d = h_in_win && v_in_win;
        pixel_d     = BG_COLOR;
        if (in_window_d) begin
            if (front_q[~col]) begin
                pixel_d = FG_COLOR;
            end
`ifdef CHIP8_SCANOUT_BORDER_EN
        end else if ((hcount_in >= X_LO - 11'd1) && (hcount_in <= X_HI) &&
                     (vcount_ext >= Y_LO - 11'd1) && (vcount_ext <= Y_HI)) begin
            pixel_d = 24'h808080;
`endif
        end
    end

    // State, line buffers and registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            byte_q      <= 3'd0;
            row_q       <= 5'd0;
            back_q      <= 64'd0;
            front_q     <= 64'd0;
            disp_q      <= 1'b0;
            underrun_q  <= 1'b0;
            pixel_q     <= 24'd0;
            in_window_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            row_q       <= row_d;
            back_q      <= back_d;
            front_q     <= front_d;
            disp_q      <= disp_d;
            underrun_q  <= underrun_d;
            pixel_q     <= pixel_d;
            in_window_q <= in_window_d;
        end
    end

    assign mem.mem_addr_out  = {7'b0, disp_q, row_q, byte_q};
    assign mem.mem_valid_out = req;
    assign mem.mem_type_out  = 1'b1;
    assign pixel_out         = pixel_q;
    assign in_window_out     = in_window_q;
    assign underrun_out      = underrun_q;
    assign state_dbg_out     = state_q;

endmodule

// File: tb/tb_chip8_scanout.sv
// tb_chip8_scanout: directed bench for chip8_scanout with a small VRAM
// responder that answers each read two cycles after it is issued.
module tb_chip8_scanout;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        new_frame;
    logic        ad;
    logic [23:0] pixel;
    logic        in_win;
    logic        underrun;
    logic [1:0]  state_dbg;

    chip8_scanout_if mif ();

    chip8_scanout dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .new_frame_in  (new_frame),
        .ad_in         (ad),
        .mem           (mif),
        .pixel_out     (pixel),
        .in_window_out (in_win),
        .underrun_out  (underrun),
        .state_dbg_out (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- VRAM responder ----------------
    logic [7:0]  vram [0:511];
    int          resp_cnt = 0;
    logic [15:0] pend_addr = 16'd0;
    logic        inj_valid = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            resp_cnt         = 0;
            mif.mem_valid_in = 1'b0;
            mif.mem_data_in  = 8'd0;
        end else begin
            mif.mem_valid_in = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mif.mem_valid_in = 1'b1;
                    mif.mem_data_in  = vram[pend_addr[8:0]];
                end
            end
            if (inj_valid) begin
                mif.mem_valid_in = 1'b1;
                mif.mem_data_in  = 8'hAA;
            end
            if (mif.mem_valid_out) begin
                got_q.push_back(mif.mem_addr_out);
                pend_addr = mif.mem_addr_out;
                resp_cnt  = 2;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] h, input logic [9:0] v);
        hcount = h;
        vcount = v;
        tick();
    endtask

    task automatic pix(input string tag, input logic [10:0] h, input logic [9:0] v,
                       input logic [23:0] exp_p, input logic exp_w);
        drive(h, v);
        check({tag, "_pix"}, pixel, exp_p);
        check({tag, "_win"}, in_win, exp_w);
    endtask

    task automatic pulse_nf(input logic ad_val);
        ad        = ad_val;
        new_frame = 1'b1;
        drive(11'd1300, 10'd620);
        new_frame = 1'b0;
    endtask

    // Trigger a fetch at the end of line v, wait for DONE, compare the
    // eight request addresses, then cross the swap point on line v+1.
    task automatic fetch_row(input string tag, input logic nf, input logic [9:0] v,
                             input logic [15:0] base);
        logic [15:0] e;
        logic [15:0] a;
        got_q.delete();
        new_frame = nf;
        drive(11'd1280, v);
        new_frame = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (state_dbg == 2'd3) break;
            drive(11'd1281, v);
        end
        check({tag, "_done"}, state_dbg, 2'd3);
        check({tag, "_nreq"}, got_q.size(), 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(base + 16'(i));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (got_q.size() > 0) ? got_q.pop_front() : 16'hDEAD;
            check({tag, "_addr"}, a, e);
        end
        drive(11'd0, v + 10'd1);
        check({tag, "_swap_underrun"}, underrun, 1'b0);
        check({tag, "_swap_idle"}, state_dbg, 2'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 512; i++) vram[i] = 8'h00;
        vram[9'h000] = 8'h80;   // buf0 row0: col 0 set
        vram[9'h100] = 8'h40;   // buf1 row0: col 1 set
        vram[9'h110] = 8'h01;   // buf1 row2: col 7 set
        vram[9'h0F8] = 8'hFF;   // buf0 row31: cols 0..7 set
        vram[9'h0FF] = 8'h01;   // buf0 row31: col 63 set

        rst_n            = 1'b0;
        hcount           = 11'd1300;
        vcount           = 10'd620;
        new_frame        = 1'b0;
        ad               = 1'b0;
        mif.mem_ready_in = 1'b1;
        #12;
        check("rst_pix", pixel, 24'd0);
        check("rst_win", in_win, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_mvalid", mif.mem_valid_out, 1'b0);
        check("rst_mtype", mif.mem_type_out, 1'b1);
        check("rst_maddr", mif.mem_addr_out, 16'h0000);
        check("rst_state", state_dbg, 2'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Row fetch from buffer 0 and pixel mapping
        pulse_nf(1'b1);
        fetch_row("row0_buf0", 1'b0, 10'd103, 16'h0000);
        pix("h127", 11'd127, 10'd104, BG, 1'b0);
        pix("h128", 11'd128, 10'd104, FG, 1'b1);
        pix("h143", 11'd143, 10'd104, FG, 1'b1);
        pix("h144", 11'd144, 10'd104, BG, 1'b1);
        pix("h1151", 11'd1151, 10'd104, BG, 1'b1);
        pix("h1152", 11'd1152, 10'd104, BG, 1'b0);
        pix("v119", 11'd130, 10'd119, FG, 1'b1);

        // Buffer select: ad_in=0 at new_frame, then toggle mid-frame
        pulse_nf(1'b0);
        ad = 1'b1;
        drive(11'd1300, 10'd620);
        drive(11'd1300, 10'd620);
        fetch_row("row0_buf1", 1'b0, 10'd103, 16'h0100);
        pix("b1_h128", 11'd128, 10'd104, BG, 1'b1);
        pix("b1_h144", 11'd144, 10'd104, FG, 1'b1);
        pix("b1_h159", 11'd159, 10'd104, FG, 1'b1);
        pix("b1_h160", 11'd160, 10'd104, BG, 1'b1);

        // Underrun: arbiter never ready through hblank
        mif.mem_ready_in = 1'b0;
        got_q.delete();
        drive(11'd1280, 10'd119);
        for (int i = 0; i < 20; i++) drive(11'd1281, 10'd119);
        check("ur_stuck_req", state_dbg, 2'd1);
        check("ur_no_req", got_q.size(), 0);
        drive(11'd0, 10'd120);
        check("ur_pulse", underrun, 1'b1);
        check("ur_idle", state_dbg, 2'd0);
        drive(11'd1, 10'd120);
        check("ur_pulse_end", underrun, 1'b0);
        pix("ur_blank", 11'd144, 10'd120, BG, 1'b1);
        mif.mem_ready_in = 1'b1;
        fetch_row("row2_buf1", 1'b0, 10'd135, 16'h0110);
        pix("r2_h240", 11'd240, 10'd136, FG, 1'b1);
        pix("r2_h239", 11'd239, 10'd136, BG, 1'b1);

        // Last row with new_frame coincident with the trigger (ad_in=1 -> buf0)
        ad = 1'b1;
        fetch_row("row31", 1'b1, 10'd599, 16'h00F8);
        pix("r31_h128", 11'd128, 10'd600, FG, 1'b1);
        pix("r31_h255", 11'd255, 10'd600, FG, 1'b1);
        pix("r31_h256", 11'd256, 10'd600, BG, 1'b1);
        pix("r31_h1135", 11'd1135, 10'd600, BG, 1'b1);
        pix("r31_h1151", 11'd1151, 10'd600, FG, 1'b1);
        pix("v615", 11'd128, 10'd615, FG, 1'b1);
        got_q.delete();
        drive(11'd1280, 10'd615);
        for (int i = 0; i < 5; i++) drive(11'd1281, 10'd615);
        check("v615_no_fetch_state", state_dbg, 2'd0);
        check("v615_no_fetch_req", got_q.size(), 0);
        pix("v616", 11'd128, 10'd616, BG, 1'b0);
        drive(11'd0, 10'd616);
        check("v616_no_swap", underrun, 1'b0);
        pix("v615_kept", 11'd128, 10'd615, FG, 1'b1);
        pix("v103_out", 11'd128, 10'd103, BG, 1'b0);

        // Reset in the middle of a fetch
        drive(11'd1280, 10'd103);
        drive(11'd130, 10'd600);
        drive(11'd130, 10'd600);
        drive(11'd130, 10'd600);
        check("mid_pix_fg", pixel, FG);
        check("mid_busy", (state_dbg == 2'd1) || (state_dbg == 2'd2), 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pix", pixel, 24'd0);
        check("mid_rst_win", in_win, 1'b0);
        check("mid_rst_mvalid", mif.mem_valid_out, 1'b0);
        check("mid_rst_maddr", mif.mem_addr_out, 16'h0000);
        check("mid_rst_mtype", mif.mem_type_out, 1'b1);
        check("mid_rst_state", state_dbg, 2'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        inj_valid = 1'b1;
        drive(11'd1300, 10'd620);
        inj_valid = 1'b0;
        drive(11'd1300, 10'd620);
        check("late_resp_ignored", state_dbg, 2'd0);
        for (int i = 0; i < 10; i++) begin
            drive(11'd1300, 10'd620);
            check("post_rst_no_req", mif.mem_valid_out, 1'b0);
        end
        pix("post_rst_blank", 11'd128, 10'd104, BG, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/chip8_scanout.md
Name: chip8_scanout

Overview:
- Downstream consumer of the chip-8 VRAM framebuffer written by the sprite/clear engine.
- Once per source row, fetches the 8 bytes of that 64x32 1-bpp row from VRAM over the shared memory handshake into a line buffer.
- Emits a scaled, offset RGB pixel stream aligned to the video timing generator's hcount/vcount.
- Honours double buffering: displays the buffer not currently being drawn, with the selection latched once per frame.

Parameters:
- SCALE_LOG2, 4, log2 of integer upscale (4 gives 16x, a 1024x512 window).
- X_OFFSET, 128, first screen column of the window.
- Y_OFFSET, 104, first screen line of the window.
- H_ACTIVE, 1280, active pixels per line; hcount == H_ACTIVE marks the start of hblank.
- FG_COLOR, 24'hFFFFFF, RGB for a set pixel.
- BG_COLOR, 24'h000000, RGB for a clear pixel, and for pixels outside the window.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous, active-low reset
- hcount_in  input  11  current pixel column from the timing generator
- vcount_in  input  10  current line from the timing generator
- new_frame_in  input  1  one-cycle pulse at start of vertical blank
- ad_in  input  1  buffer the drawing engine is writing; scanout displays ~ad_in
- mem_ready_in  input  1  arbiter can accept a request this cycle
- mem_valid_in  input  1  read data valid
- mem_data_in  input  8  read data, MSB = leftmost pixel
- mem_addr_out  output  16  {7'b0, disp_buf, row[4:0], byte[2:0]}
- mem_valid_out  output  1  one-cycle read request strobe
- mem_type_out  output  1  constant 1 (VRAM)
- pixel_out  output  24  RGB, one cycle latency
- in_window_out  output  1  pixel_out lies inside the 1024x512 window
- underrun_out  output  1  one-cycle pulse when a row fetch missed its deadline

Behaviour:
- Reset (rst_in low, async): all outputs 0 except mem_type_out=1. FSM=IDLE. Both line buffers 0, disp_buf=0.
- Reset mid-fetch: abandon the fetch. A late mem_valid_in after reset release is ignored while in IDLE.
- Buffer select: on new_frame_in, disp_buf <= ~ad_in. A change of ad_in mid-frame has no effect until the next new_frame_in.
- Fetch trigger: in IDLE, when hcount_in == H_ACTIVE and the next line nv = vcount_in+1 satisfies both:
  - Y_OFFSET <= nv < Y_OFFSET + (32<<SCALE_LOG2)
  - (nv - Y_OFFSET) mod 2^SCALE_LOG2 == 0
  Then latch row = (nv - Y_OFFSET) >> SCALE_LOG2, set byte=0, and go to REQ.
- REQ: when mem_ready_in, assert mem_valid_out for exactly one cycle with mem_addr_out, then go to WAIT. Otherwise hold mem_valid_out=0.
- WAIT: on mem_valid_in, write mem_data_in to back_line[63-8*byte -: 8].
  - If byte==7, go to DONE; else byte++ and return to REQ.
  - At most one request outstanding; mem_valid_out never asserted in WAIT.
- DONE: hold until the swap point.
- Swap point: hcount_in == 0 on a line whose (vcount - Y_OFFSET) mod 2^SCALE_LOG2 == 0 inside the window.
  - If FSM==DONE: front_line <= back_line, FSM -> IDLE.
  - Otherwise: front_line <= 0, pulse underrun_out, abort the fetch (FSM -> IDLE, pending response ignored).
- Pixel path, registered, 1 cycle:
  - in_window = X_OFFSET <= hcount < X_OFFSET + (64<<SCALE_LOG2), and vcount within the window.
  - col = (hcount - X_OFFSET) >> SCALE_LOG2.
  - pixel_out = in_window ? (front_line[63-col] ? FG_COLOR : BG_COLOR) : BG_COLOR.
  - in_window_out tracks in_window with the same one-cycle delay.
- Width rules:
  - Subtractions evaluated at 11 bits; col uses 6 bits and row 5 bits after bounds checks.
  - byte counter 3 bits, no wrap beyond 7.
- Simultaneous new_frame_in and a fetch trigger: disp_buf updates first. The fetch uses the new disp_buf, since the address is formed in REQ.
- Lines outside the window: no fetches and no swaps.

Optional Feature:
- Macro: CHIP8_SCANOUT_BORDER_EN.
- Defined: pixels exactly one column/line outside the window (a 1-pixel frame) output 24'h808080; in_window_out remains 0 for them.
- Undefined: those pixels output BG_COLOR. No extra logic is present.

Test Plan:
- Reset: hold rst_in=0 mid-stream -> all outputs 0 immediately (async) except mem_type_out=1; no mem_valid_out for 10 cycles after release.
- Row fetch: vcount=103, hcount=1280, ad_in=1, new_frame seen, mem_ready always 1, data returned 2 cycles after each request:
  - Expected: 8 strobes with addresses 0x0000..0x0007 (disp_buf=0).
  - Expected: front_line loaded at vcount=104, hcount=0.
- Pixel mapping: VRAM row0 byte0=0x80, others 0:
  - Expected: pixel_out=FG for hcount 128..143 (one cycle later).
  - Expected: BG at hcount 144 and at 127.
  - Expected: in_window_out 0 at hcount 1152.
- Buffer select: ad_in=0 at new_frame -> fetch addresses 0x0100..0x0107. Toggling ad_in mid-frame leaves addresses unchanged.
- Underrun: mem_ready_in held 0 through hblank -> underrun_out single pulse at hcount=0; row displays all BG; next row fetches normally.
- Last row and bottom edge:
  - vcount=599 triggers row 31 (addresses 0x00F8..0x00FF).
  - vcount=615 triggers nothing.
  - Lines >=616 show BG with in_window_out=0.
